hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Stall and flush sequencer for the 5-stage MIPS pipeline, placed beside the forwarding unit. It detects load-use hazards, flushes on taken branches, and holds the pipeline while a multi-cycle mul/div occupies EX. Its outputs drive the PC, IF/ID, ID/EX and EX/MEM pipeline-register controls. A saturating counter records the number of stall cycles for performance reporting.

## Interface
- MD_LATENCY, 4, total cycles a mul/div spends in EX; legal range 2..16
- CNT_W, 16, width of the stall counter

- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-low
- IFID_RS  in  5  rs of the instruction in ID
- IFID_RT  in  5  rt of the instruction in ID
- IFID_UsesRT  in  1  the ID instruction reads rt as a source
- IDEX_RT  in  5  rt (load destination) of the instruction in EX
- IDEX_MemRead  in  1  the EX instruction is a load
- md_start_i  in  1  the EX instruction is mul/div; level, held while the op sits in ID/EX
- branch_taken_i  in  1  branch resolved taken in EX this cycle
- PC_Write  out  1  PC load enable
- IFID_Write  out  1  IF/ID register enable
- IDEX_Write  out  1  ID/EX register enable
- IFID_Flush  out  1  zero IF/ID on the next edge
- IDEX_Flush  out  1  load a bubble into ID/EX on the next edge
- EXMem_Flush  out  1  load a bubble into EX/MEM on the next edge
- md_busy_o  out  1  mul/div stall in progress
- md_done_o  out  1  one-cycle pulse; mul/div result valid in EX this cycle
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- States: RUN, MD_WAIT. A down-counter `cnt` (4 bits) is used in MD_WAIT.
- Outputs are Mealy: they are combinational from the state, `cnt` and the inputs.
- Default outputs: all enables = 1, all flushes = 0, md_busy_o = 0, md_done_o = 0.
- Priority in RUN, highest first:
  - 1. **branch_taken_i.** IFID_Flush = 1, IDEX_Flush = 1, PC_Write = 1. Any load-use hazard or md_start_i in the same cycle is ignored. Next state RUN.
  - 2. **md_start_i.** PC_Write = 0, IFID_Write = 0, IDEX_Write = 0, EXMem_Flush = 1, md_busy_o = 1. Next state MD_WAIT with cnt <= MD_LATENCY-2.
  - 3. **Load-use hazard.** Condition: IDEX_MemRead && IDEX_RT != 0 && (IDEX_RT == IFID_RS || (IFID_UsesRT && IDEX_RT == IFID_RT)). Response: PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1 for one cycle. Next state RUN; the hazard clears on its own once the load advances.
- MD_WAIT:
  - If cnt != 0: apply the same stall outputs as RUN priority 2, and decrement cnt. branch_taken_i, md_start_i and load-use are ignored.
  - If cnt == 0 (release cycle): default outputs, md_done_o = 1. Load-use detection is active in this cycle. md_start_i is ignored. Next state RUN.
- Back-to-back mul/div: the next op asserts md_start_i in RUN on the cycle after release, and the sequence restarts.
- stall_cnt_o increments by 1 on every cycle where PC_Write = 0. It saturates at 2^CNT_W-1. Flush-only cycles are not counted.
- Simultaneous branch_taken_i and md_start_i is illegal, because both refer to the same EX slot. If it occurs, the branch wins.

## Timing
- Reset: while rst_i = 0 at an edge, state <= RUN, cnt <= 0, stall_cnt_o <= 0.
- While rst_i = 0, outputs are forced to their reset values, independent of other inputs:
  - PC_Write = IFID_Write = IDEX_Write = 1
  - all flushes = 0
  - md_busy_o = md_done_o = 0
- Reset asserted during MD_WAIT aborts the operation with no md_done_o pulse.
- Mul/div sequence: the start cycle is k = 0. Stall is asserted for cycles 0..MD_LATENCY-2 (MD_LATENCY-1 cycles). Release with md_done_o is at cycle MD_LATENCY-1. The op occupies EX for exactly MD_LATENCY cycles.
- Load-use costs exactly 1 stall cycle; a branch costs 2 flushed slots and 0 stall cycles.
- MD_LATENCY = 2: no decrement cycles. The state goes RUN -> MD_WAIT (cnt = 0) -> RUN, with one stall cycle.

## Structure
- Package hazard_pkg holds:
  - the state enum {RUN, MD_WAIT}
  - the default MD_LATENCY
  - the register-number constant ZERO_REG = 5'd0
- One sub-module, md_wait_counter: loads MD_LATENCY-2, decrements, and flags zero.
- The load-use compare, priority logic and stall counter stay in the top module.

## Test plan
- Load-use hazard: IDEX_MemRead = 1, IDEX_RT = 8, IFID_RS = 8 -> one cycle with PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1; stall_cnt_o 0 -> 1. Repeat with IDEX_RT = 0 -> no stall.
- Hazard on rt only: IDEX_RT = 9 = IFID_RT with IFID_UsesRT = 0 -> no stall; with IFID_UsesRT = 1 -> one stall cycle.
- Mul/div with MD_LATENCY = 4: md_start_i at k = 0 -> stall and EXMem_Flush at k = 0..2, md_done_o at k = 3, stall_cnt_o += 3. Back-to-back ops -> 6 stall cycles and two md_done_o pulses.
- Branch taken with a load-use hazard in the same cycle -> IFID_Flush = IDEX_Flush = 1, PC_Write = 1, no stall counted.
- Reset: rst_i = 0 at k = 1 of a mul/div -> next cycle state RUN, stall_cnt_o = 0, no md_done_o. Also run with CNT_W = 2 for five stall cycles -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard sequencer: FSM state encoding, the
// default mul/div latency and the hard-wired zero register number.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

  localparam int MD_LATENCY_DEF = 4;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/md_wait_counter.sv
// Mul/div wait counter.
//   clk      : clock
//   rst_n    : synchronous active-low reset, clears the count
//   load     : load MD_LATENCY-2 (start of a mul/div)
//   dec      : decrement by one (ignored when already zero)
//   cnt_zero : count is zero; marks the release cycle in MD_WAIT
module md_wait_counter #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic cnt_zero
);

  localparam logic [3:0] LOAD_VAL = 4'(MD_LATENCY - 2);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign cnt_zero = (cnt == 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, flushes IF/ID and ID/EX on a taken branch and
// holds the front of the pipeline while a multi-cycle mul/div sits in EX.
// Inputs : clk_i, rst_i (sync, active-low), IFID_RS/IFID_RT/IFID_UsesRT
//          (ID sources), IDEX_RT/IDEX_MemRead (EX load), md_start_i,
//          branch_taken_i.
// Outputs: PC_Write, IFID_Write, IDEX_Write (enables), IFID_Flush,
//          IDEX_Flush, EXMem_Flush (bubbles), md_busy_o, md_done_o,
//          stall_cnt_o (saturating count of cycles with PC_Write = 0).
// All control outputs are Mealy: combinational from state, counter and inputs.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IFID_RS,
  input  logic [4:0]       IFID_RT,
  input  logic             IFID_UsesRT,
  input  logic [4:0]       IDEX_RT,
  input  logic             IDEX_MemRead,
  input  logic             md_start_i,
  input  logic             branch_taken_i,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMem_Flush,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  hz_state_t state, state_nxt;
  logic      load_use;
  logic      md_load;
  logic      md_dec;
  logic      cnt_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A load into $zero never produces a value, so it cannot create a hazard.
  assign load_use = IDEX_MemRead && (IDEX_RT != ZERO_REG) &&
                    ((IDEX_RT == IFID_RS) || (IFID_UsesRT && (IDEX_RT == IFID_RT)));

  md_wait_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_cnt (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (md_load),
    .dec      (md_dec),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMem_Flush = 1'b0;
    md_busy_o   = 1'b0;
    md_done_o   = 1'b0;
    md_load     = 1'b0;
    md_dec      = 1'b0;
    // During reset the defaults above are forced regardless of inputs.
    if (rst_i) begin
      case (state)
        RUN: begin
          if (branch_taken_i) begin
            // Branch wins over everything sharing its EX slot.
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (md_start_i) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMem_Flush = 1'b1;
            md_busy_o   = 1'b1;
            md_load     = 1'b1;
            state_nxt   = MD_WAIT;
          end else if (load_use) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!cnt_zero) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Write  = 1'b0;
            EXMem_Flush = 1'b1;
            md_busy_o   = 1'b1;
            md_dec      = 1'b1;
          end else begin
            // Release cycle: result valid, ID instruction may still need
            // a load-use bubble; a held md_start_i is the same op, ignore it.
            md_done_o = 1'b1;
            state_nxt = RUN;
            if (load_use) begin
              PC_Write   = 1'b0;
              IFID_Write = 1'b0;
              IDEX_Flush = 1'b1;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (!PC_Write) begin
      stall_cnt_o <= sat_inc(stall_cnt_o);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs = '0, rt = '0, idex_rt = '0;
  logic       uses_rt = 1'b0, memread = 1'b0, md_start = 1'b0, br = 1'b0;

  logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, exm_f, busy, done;
  logic [15:0] cnt;
  logic        s_pc_w, s_ifid_w, s_idex_w, s_ifid_f, s_idex_f, s_exm_f, s_busy, s_done;
  logic [1:0]  s_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS(rs), .IFID_RT(rt), .IFID_UsesRT(uses_rt),
    .IDEX_RT(idex_rt), .IDEX_MemRead(memread),
    .md_start_i(md_start), .branch_taken_i(br),
    .PC_Write(pc_w), .IFID_Write(ifid_w), .IDEX_Write(idex_w),
    .IFID_Flush(ifid_f), .IDEX_Flush(idex_f), .EXMem_Flush(exm_f),
    .md_busy_o(busy), .md_done_o(done), .stall_cnt_o(cnt)
  );

  hazard_ctrl #(.MD_LATENCY(2), .CNT_W(2)) u_sm (
    .clk_i(clk), .rst_i(rst),
    .IFID_RS(rs), .IFID_RT(rt), .IFID_UsesRT(uses_rt),
    .IDEX_RT(idex_rt), .IDEX_MemRead(memread),
    .md_start_i(md_start), .branch_taken_i(br),
    .PC_Write(s_pc_w), .IFID_Write(s_ifid_w), .IDEX_Write(s_idex_w),
    .IFID_Flush(s_ifid_f), .IDEX_Flush(s_idex_f), .EXMem_Flush(s_exm_f),
    .md_busy_o(s_busy), .md_done_o(s_done), .stall_cnt_o(s_cnt)
  );

  // Control vector order: {PC_Write, IFID_Write, IDEX_Write, IFID_Flush,
  //                        IDEX_Flush, EXMem_Flush, md_busy_o, md_done_o}
  localparam logic [7:0] C_IDLE = 8'b1110_0000;
  localparam logic [7:0] C_LU   = 8'b0010_1000;
  localparam logic [7:0] C_MD   = 8'b0000_0110;
  localparam logic [7:0] C_DONE = 8'b1110_0001;
  localparam logic [7:0] C_BR   = 8'b1111_1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, pc_w, ifid_w, idex_w, ifid_f, idex_f, exm_f, busy, done}, {24'd0, exp});
  endtask

  task automatic chk_sm(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, {24'd0, s_pc_w, s_ifid_w, s_idex_w, s_ifid_f, s_idex_f, s_exm_f, s_busy, s_done},
        {24'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs = '0; rt = '0; idex_rt = '0; uses_rt = 1'b0;
    memread = 1'b0; md_start = 1'b0; br = 1'b0;
  endtask

  initial begin
    // Reset with hazard-provoking inputs: outputs must stay at defaults
    tick();
    memread = 1'b1; idex_rt = 5'd8; rs = 5'd8; md_start = 1'b1; br = 1'b1;
    chk_ctl("rst_forced", C_IDLE);
    tick();
    chk("rst_cnt", 32'(cnt), 32'd0);
    clear_in();
    rst = 1'b1;
    chk_ctl("idle", C_IDLE);

    // Load-use on rs
    memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
    chk_ctl("lu_rs", C_LU);
    tick();
    chk("lu_rs_cnt", 32'(cnt), 32'd1);
    memread = 1'b0;
    chk_ctl("lu_cleared", C_IDLE);
    tick();
    chk("lu_cleared_cnt", 32'(cnt), 32'd1);

    // Load into $zero never stalls
    memread = 1'b1; idex_rt = 5'd0; rs = 5'd0;
    chk_ctl("lu_zero", C_IDLE);
    tick();
    chk("lu_zero_cnt", 32'(cnt), 32'd1);

    // rt match only counts when ID uses rt
    idex_rt = 5'd9; rt = 5'd9; rs = 5'd3; uses_rt = 1'b0;
    chk_ctl("rt_unused", C_IDLE);
    uses_rt = 1'b1;
    chk_ctl("rt_used", C_LU);
    tick();
    chk("rt_used_cnt", 32'(cnt), 32'd2);
    clear_in();

    // Single mul/div, load-use pending in the release cycle
    md_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_ctl($sformatf("md1_k%0d", k), C_MD);
      tick();
    end
    memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
    chk_ctl("md1_release_lu", C_LU | 8'b0000_0001);
    tick();
    chk("md1_cnt", 32'(cnt), 32'd6);
    clear_in();
    chk_ctl("md1_after", C_IDLE);

    // Back-to-back mul/div, stray branch inside MD_WAIT is ignored
    md_start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      br = (k == 1);
      chk_ctl($sformatf("b2b_k%0d", k), ((k % 4) == 3) ? C_DONE : C_MD);
      tick();
    end
    clear_in();
    chk("b2b_cnt", 32'(cnt), 32'd12);

    // Branch beats load-use and mul/div start in the same cycle
    br = 1'b1; memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
    chk_ctl("br_lu", C_BR);
    memread = 1'b0; md_start = 1'b1;
    chk_ctl("br_md", C_BR);
    tick();
    clear_in();
    chk_ctl("br_after", C_IDLE);
    chk("br_cnt", 32'(cnt), 32'd12);

    // Reset at k = 1 of a mul/div aborts it with no done pulse
    md_start = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("rst_mid_md", C_IDLE);
    tick();
    rst = 1'b1;
    md_start = 1'b0;
    chk_ctl("rst_md_after", C_IDLE);
    chk("rst_md_cnt", 32'(cnt), 32'd0);
    chk("rst_md_scnt", 32'(s_cnt), 32'd0);

    // MD_LATENCY = 2: one stall cycle, then release
    md_start = 1'b1;
    chk_sm("lat2_k0", C_MD);
    tick();
    chk_sm("lat2_k1", C_DONE);
    tick();
    md_start = 1'b0;
    chk("lat2_cnt", 32'(s_cnt), 32'd1);

    // Held load-use: 5 more stall cycles; 2-bit counter saturates at 3
    memread = 1'b1; idex_rt = 5'd8; rs = 5'd8;
    for (int k = 0; k < 5; k++) tick();
    clear_in();
    chk("sat_scnt", 32'(s_cnt), 32'd3);
    chk("nosat_cnt", 32'(cnt), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
